vr_inst_fetch: RTL and testbench

- Instruction fetch front end. Acts as the requesting side of the combinational instruction memory: it drives the fetch address and captures the returned 32-bit instruction word.
- Maintains the fetch PC and a small prefetch queue of {PC, INST} pairs, presented to decode over a valid/ready handshake.
- Supports branch/jump redirect with a queue flush.
- Halts fetch on an all-zero word, which the instruction memory returns outside the loaded program.

---
 rtl/vr_inst_fetch.sv | 134 +++++++++++++
 tb/tb_vr_inst_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vr_inst_fetch.sv
// Instruction fetch front end: drives a combinational instruction memory and
// buffers {pc, inst} pairs in a small prefetch queue feeding decode.
module vr_inst_fetch #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    entry_t        head_q, head_d;
    entry_t        mem [DEPTH];

    logic zero_hit;
    logic push;
    logic pop;
    logic unused_pc_lsb;

    // The low address bits of a redirect target are forced to zero.
    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign imem_req  = (state_q == ST_RUN) && (cnt_q < CW'(DEPTH)) && !redirect;
    assign zero_hit  = imem_req && HALT_ON_ZERO && (imem_inst == 32'h0);
    assign push      = imem_req && !zero_hit;
    assign pop       = (cnt_q != '0) && out_ready && !redirect;

    assign imem_addr = pc_q;
    assign out_valid = (cnt_q != '0);
    assign out_inst  = head_q.inst;
    assign out_pc    = head_q.pc;
    assign halted    = (state_q == ST_HALT);

    // State register and fetch bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
        end
    end

    // Queue storage; contents are only meaningful under cnt_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= '{pc: pc_q, inst: imem_inst};
        end
    end

    // Next-state: redirect dominates, otherwise push/pop/halt bookkeeping.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        head_d  = head_q;

        if (redirect) begin
            state_d = ST_RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN:  if (zero_hit) state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RUN;
            endcase

            if (push) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end

            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase

            // Head register follows the new head; the word being pushed
            // becomes the head when nothing else remains in the queue.
            if (cnt_d != '0) begin
                if (push && ((cnt_q - CW'(pop)) == '0)) begin
                    head_d = '{pc: pc_q, inst: imem_inst};
                end else begin
                    head_d = mem[rd_d];
                end
            end
        end
    end

endmodule

// File: tb/tb_vr_inst_fetch.sv
// Directed bench for vr_inst_fetch with a combinational instruction ROM model.
module tb_vr_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    vr_inst_fetch #(.DEPTH(4), .RESET_PC(32'h0), .HALT_ON_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_inst  (imem_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Program image 0x00..0x60; words not pinned below are arbitrary non-zero.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  rom = 32'h00000513;
            32'h04:  rom = 32'h00100293;
            32'h08:  rom = 32'h00a00613;
            32'h0C:  rom = 32'h04c2dc63;
            32'h20:  rom = 32'h02034663;
            32'h60:  rom = 32'hfa0006e3;
            default: rom = (a < 32'h64) ? (32'h00000013 | {a[16:0], 15'b0}) : 32'h0;
        endcase
    endfunction

    assign imem_inst = rom(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; redirect = 1'b0;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 00000000", out_pc); end
        vectors++; if (out_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h expected 00000000", out_inst); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_req: got %b expected 1", imem_req); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 25; k++) begin
            tick();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid); end
            vectors++; if (out_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, out_pc, 32'(4 * k)); end
            vectors++; if (out_inst !== rom(32'(4 * k))) begin miscompares++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, out_inst, rom(32'(4 * k))); end
        end
        tick();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b expected 1", halted); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_req: got %b expected 0", imem_req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_drain: got %b expected 0", out_valid); end
        tick(); tick();
        vectors++; if (imem_addr !== 32'h64) begin miscompares++; $display("FAIL halt_addr: got %h expected 00000064", imem_addr); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    endtask

    task automatic test_redirect_halted();
        redirect = 1'b1; redirect_pc = 32'h0000000E;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rdh_req_during: got %b expected 0", imem_req); end
        tick();
        redirect = 1'b0;
        #1;
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rdh_halted: got %b expected 0", halted); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rdh_valid0: got %b expected 0", out_valid); end
        vectors++; if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL rdh_addr: got %h expected 0000000c", imem_addr); end
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rdh_req: got %b expected 1", imem_req); end
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rdh_valid1: got %b expected 1", out_valid); end
        vectors++; if (out_pc !== 32'hC) begin miscompares++; $display("FAIL rdh_pc: got %h expected 0000000c", out_pc); end
        vectors++; if (out_inst !== 32'h04c2dc63) begin miscompares++; $display("FAIL rdh_inst: got %h expected 04c2dc63", out_inst); end
        tick();
        vectors++; if (out_pc !== 32'h10) begin miscompares++; $display("FAIL rdh_next_pc: got %h expected 00000010", out_pc); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++; if (out_pc !== 32'h0 || out_inst !== 32'h00000513 || out_valid !== 1'b1)
                begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %h/%h expected v=1 00000000/00000513", k, out_valid, out_pc, out_inst); end
        end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_full_req: got %b expected 0", imem_req); end
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL bp_full_addr: got %h expected 00000010", imem_addr); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++; if (out_pc !== 32'(4 * k) || out_inst !== rom(32'(4 * k)))
                begin miscompares++; $display("FAIL bp_drain[%0d]: got %h/%h expected %h/%h", k, out_pc, out_inst, 32'(4 * k), rom(32'(4 * k))); end
            if (k == 1) begin
                vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL bp_refill_req: got %b expected 1", imem_req); end
            end
        end
    endtask

    task automatic test_redirect_full_pop();
        out_ready = 1'b0; rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rfp_full: got req=%b expected 0", imem_req); end
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rfp_flush: got %b expected 0", out_valid); end
        vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL rfp_addr: got %h expected 00000020", imem_addr); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_inst !== 32'h02034663)
            begin miscompares++; $display("FAIL rfp_first: got v=%b %h/%h expected v=1 00000020/02034663", out_valid, out_pc, out_inst); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req0: got %b expected 0", imem_req); end
        tick();
        vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL b2b_addr0: got %h expected 00000040", imem_addr); end
        redirect_pc = 32'h8;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req1: got %b expected 0", imem_req); end
        tick();
        vectors++; if (imem_addr !== 32'h8 || out_valid !== 1'b0)
            begin miscompares++; $display("FAIL b2b_addr1: got %h v=%b expected 00000008 v=0", imem_addr, out_valid); end
        redirect = 1'b0;
        tick();
        vectors++; if (out_pc !== 32'h8 || out_inst !== 32'h00a00613)
            begin miscompares++; $display("FAIL b2b_first: got %h/%h expected 00000008/00a00613", out_pc, out_inst); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h5C;
        tick();
        redirect = 1'b0;
        tick(); tick(); tick();
        vectors++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h5C)
            begin miscompares++; $display("FAIL ar_pre: got h=%b v=%b pc=%h expected h=1 v=1 pc=0000005c", halted, out_valid, out_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL ar_halted: got %b expected 0", halted); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL ar_addr: got %h expected 00000000", imem_addr); end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h00000513)
            begin miscompares++; $display("FAIL ar_restart: got v=%b %h/%h expected v=1 00000000/00000513", out_valid, out_pc, out_inst); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_redirect_halted();
        test_backpressure();
        test_redirect_full_pop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
